// File: rtl/pid_mc_pkg.sv
// Shared types and width helpers for the multi-channel PID/IIR core.
package pid_mc_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SAT} state_e;
    typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_e;

    localparam int NUM_TAPS = 5;

    function automatic int acc_w(int coef_w, int adc_w, int frac_w);
        return coef_w + adc_w + frac_w + 4;
    endfunction

    function automatic int hist_w(int adc_w, int frac_w);
        return adc_w + 1 + frac_w;
    endfunction

    function automatic int ch_w(int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

    // Largest output magnitude (full-scale ADC code) expressed in Q.FRAC.
    function automatic logic [127:0] lim_val(int adc_w, int frac_w);
        return ((128'd1 << adc_w) - 128'd1) << frac_w;
    endfunction

endpackage

// File: rtl/pid_coef_bank.sv
// Per-channel five-tap coefficient register file with a guarded write port.
module pid_coef_bank
    import pid_mc_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int COEF_BITWIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic                        busy_i,
    input  logic [ch_w(CHANNELS)-1:0]   wr_ch_i,
    input  logic [2:0]                  wr_idx_i,
    input  logic [COEF_BITWIDTH-1:0]    wr_data_i,
    output logic                        err_o,
    input  logic [ch_w(CHANNELS)-1:0]   rd_ch_i,
    input  logic [2:0]                  rd_tap_i,
    output logic [COEF_BITWIDTH-1:0]    rd_data_o
);

    logic signed [COEF_BITWIDTH-1:0] coef_q [CHANNELS][NUM_TAPS];
    logic signed [COEF_BITWIDTH-1:0] coef_d [CHANNELS][NUM_TAPS];
    logic                            err_q, err_d;
    logic                            wr_ok;

    assign wr_ok = !busy_i && (int'(wr_ch_i) < CHANNELS) && (int'(wr_idx_i) < NUM_TAPS);

    always_comb begin
        coef_d = coef_q;
        err_d  = 1'b0;
        if (we_i) begin
            if (wr_ok) begin
                coef_d[wr_ch_i][wr_idx_i] = wr_data_i;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            coef_q <= coef_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if ((int'(rd_ch_i) < CHANNELS) && (int'(rd_tap_i) < NUM_TAPS)) begin
            rd_data_o = coef_q[rd_ch_i][rd_tap_i];
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/pid_core_mc.sv
// Time-multiplexed multi-channel PID/IIR controller: one shared MAC, per-channel
// error/output history and coefficients, saturated output with anti-windup.
module pid_core_mc
    import pid_mc_pkg::*;
#(
    parameter int ADC_BITWIDTH  = 8,
    parameter int COEF_BITWIDTH = 32,
    parameter int FRAC_BITWIDTH = 24,
    parameter int CHANNELS      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [ch_w(CHANNELS)-1:0]   ch_i,
    input  logic [ADC_BITWIDTH-1:0]     adc_i,
    input  logic [ADC_BITWIDTH-1:0]     set_i,
    input  logic                        coef_we_i,
    input  logic [ch_w(CHANNELS)-1:0]   coef_ch_i,
    input  logic [2:0]                  coef_idx_i,
    input  logic [COEF_BITWIDTH-1:0]    coef_data_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [ADC_BITWIDTH:0]       out_val_o,
    output logic [ch_w(CHANNELS)-1:0]   out_ch_o,
    output logic                        sat_o,
    output logic                        coef_err_o
);

    localparam int CH_W   = ch_w(CHANNELS);
    localparam int ACC_W  = acc_w(COEF_BITWIDTH, ADC_BITWIDTH, FRAC_BITWIDTH);
    localparam int HIST_W = hist_w(ADC_BITWIDTH, FRAC_BITWIDTH);
    localparam int E_W    = ADC_BITWIDTH + 1;
    localparam int PU_W   = COEF_BITWIDTH + HIST_W;
    localparam logic signed [ACC_W-1:0] LIM = ACC_W'(lim_val(ADC_BITWIDTH, FRAC_BITWIDTH));

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] a);
        if (a > LIM)       return LIM;
        else if (a < -LIM) return -LIM;
        else               return a;
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] a);
        return (a > LIM) || (a < -LIM);
    endfunction

    state_e                   state_q, state_d;
    tap_e                     tap_q, tap_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [E_W-1:0]    e0_q, e0_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [E_W-1:0]    e1_q [CHANNELS];
    logic signed [E_W-1:0]    e1_d [CHANNELS];
    logic signed [E_W-1:0]    e2_q [CHANNELS];
    logic signed [E_W-1:0]    e2_d [CHANNELS];
    logic signed [HIST_W-1:0] u1_q [CHANNELS];
    logic signed [HIST_W-1:0] u1_d [CHANNELS];
    logic signed [HIST_W-1:0] u2_q [CHANNELS];
    logic signed [HIST_W-1:0] u2_d [CHANNELS];
    logic signed [E_W-1:0]    out_val_q, out_val_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic                     sat_q, sat_d;
    logic                     done_q, done_d;

    logic                     busy;
    logic                     start_ok;
    logic [COEF_BITWIDTH-1:0] coef_rd;
    logic signed [COEF_BITWIDTH-1:0] coef_s;
    logic signed [E_W-1:0]    e_sel;
    logic signed [HIST_W-1:0] u_sel;
    logic signed [PU_W-1:0]   prod_u;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  clamped;

    assign busy     = (state_q != IDLE);
    assign start_ok = start_i && (state_q == IDLE) && (int'(ch_i) < CHANNELS);

    pid_coef_bank #(
        .CHANNELS      (CHANNELS),
        .COEF_BITWIDTH (COEF_BITWIDTH)
    ) u_coef_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (coef_we_i),
        .busy_i    (busy),
        .wr_ch_i   (coef_ch_i),
        .wr_idx_i  (coef_idx_i),
        .wr_data_i (coef_data_i),
        .err_o     (coef_err_o),
        .rd_ch_i   (ch_q),
        .rd_tap_i  (tap_q),
        .rd_data_o (coef_rd)
    );

    // Tap product: error taps are integer x Q.FRAC, history taps rescale back to Q.FRAC.
    always_comb begin
        coef_s = $signed(coef_rd);
        e_sel  = e0_q;
        u_sel  = u1_q[ch_q];
        case (tap_q)
            B1:      e_sel = e1_q[ch_q];
            B2:      e_sel = e2_q[ch_q];
            A2:      u_sel = u2_q[ch_q];
            default: ;
        endcase
        prod_u = PU_W'(coef_s) * PU_W'(u_sel);
        if (tap_q == A1 || tap_q == A2) begin
            prod = ACC_W'(prod_u >>> FRAC_BITWIDTH);
        end else begin
            prod = ACC_W'(coef_s) * ACC_W'(e_sel);
        end
    end

    assign clamped = sat_clamp(acc_q);

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        ch_d      = ch_q;
        e0_d      = e0_q;
        acc_d     = acc_q;
        e1_d      = e1_q;
        e2_d      = e2_q;
        u1_d      = u1_q;
        u2_d      = u2_q;
        out_val_d = out_val_q;
        out_ch_d  = out_ch_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = MAC;
                    tap_d   = B0;
                    ch_d    = ch_i;
                    e0_d    = $signed({1'b0, set_i}) - $signed({1'b0, adc_i});
                end
            end
            MAC: begin
                acc_d = ((tap_q == B0) ? '0 : acc_q) + prod;
                if (tap_q == A2) begin
                    state_d = SAT;
                end else begin
                    tap_d = tap_e'(tap_q + 3'd1);
                end
            end
            SAT: begin
                out_val_d      = E_W'(clamped >>> FRAC_BITWIDTH);
                out_ch_d       = ch_q;
                sat_d          = sat_hit(acc_q);
                done_d         = 1'b1;
                // Store the clamped value so the feedback path cannot wind up.
                e2_d[ch_q]     = e1_q[ch_q];
                e1_d[ch_q]     = e0_q;
                u2_d[ch_q]     = u1_q[ch_q];
                u1_d[ch_q]     = HIST_W'(clamped);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tap_q     <= B0;
            ch_q      <= '0;
            e1_q      <= '{default: '0};
            e2_q      <= '{default: '0};
            u1_q      <= '{default: '0};
            u2_q      <= '{default: '0};
            out_val_q <= '0;
            out_ch_q  <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            ch_q      <= ch_d;
            e1_q      <= e1_d;
            e2_q      <= e2_d;
            u1_q      <= u1_d;
            u2_q      <= u2_d;
            out_val_q <= out_val_d;
            out_ch_q  <= out_ch_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        e0_q  <= e0_d;
        acc_q <= acc_d;
    end

    assign busy_o    = busy;
    assign done_o    = done_q;
    assign out_val_o = out_val_q;
    assign out_ch_o  = out_ch_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_pid_core_mc.sv
// Self-checking bench for pid_core_mc: directed table, hand sequences, random vs model.
module tb_pid_core_mc;

    localparam int ADC_W  = 8;
    localparam int COEF_W = 32;
    localparam int FRAC_W = 24;
    localparam int CHN    = 4;
    localparam int CHW    = 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [CHW-1:0]    ch_i = '0;
    logic [ADC_W-1:0]  adc_i = '0;
    logic [ADC_W-1:0]  set_i = '0;
    logic              coef_we_i = 1'b0;
    logic [CHW-1:0]    coef_ch_i = '0;
    logic [2:0]        coef_idx_i = '0;
    logic [COEF_W-1:0] coef_data_i = '0;
    logic              busy_o, done_o, sat_o, coef_err_o;
    logic [ADC_W:0]    out_val_o;
    logic [CHW-1:0]    out_ch_o;

    always #5 clk = ~clk;

    pid_core_mc #(
        .ADC_BITWIDTH  (ADC_W),
        .COEF_BITWIDTH (COEF_W),
        .FRAC_BITWIDTH (FRAC_W),
        .CHANNELS      (CHN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .ch_i        (ch_i),
        .adc_i       (adc_i),
        .set_i       (set_i),
        .coef_we_i   (coef_we_i),
        .coef_ch_i   (coef_ch_i),
        .coef_idx_i  (coef_idx_i),
        .coef_data_i (coef_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .out_val_o   (out_val_o),
        .out_ch_o    (out_ch_o),
        .sat_o       (sat_o),
        .coef_err_o  (coef_err_o)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wr_coef(input int ch, input int idx, input logic [31:0] d, output bit err);
        coef_we_i   = 1'b1;
        coef_ch_i   = CHW'(ch);
        coef_idx_i  = 3'(idx);
        coef_data_i = d;
        tick();
        coef_we_i = 1'b0;
        err = coef_err_o;
    endtask

    task automatic run(input int ch, input int sp, input int ad,
                       output longint val, output bit sat, output int och, output int lat);
        start_i = 1'b1;
        ch_i    = CHW'(ch);
        set_i   = ADC_W'(sp);
        adc_i   = ADC_W'(ad);
        tick();
        start_i = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done_o) begin
                lat = i;
                break;
            end
        end
        val = longint'($signed(out_val_o));
        sat = sat_o;
        och = int'(out_ch_o);
    endtask

    // Behavioural reference: direct evaluation of the difference equation.
    logic signed [127:0] mc  [CHN][5];
    logic signed [127:0] me1 [CHN];
    logic signed [127:0] me2 [CHN];
    logic signed [127:0] mu1 [CHN];
    logic signed [127:0] mu2 [CHN];

    task automatic m_reset();
        for (int c = 0; c < CHN; c++) begin
            for (int t = 0; t < 5; t++) mc[c][t] = '0;
            me1[c] = '0; me2[c] = '0; mu1[c] = '0; mu2[c] = '0;
        end
    endtask

    task automatic m_write(input int ch, input int idx, input logic signed [31:0] d);
        mc[ch][idx] = d;
    endtask

    task automatic m_run(input int ch, input int sp, input int ad, output longint val, output bit sat);
        logic signed [127:0] e, acc, lim, cl;
        e   = sp - ad;
        acc = mc[ch][0] * e + mc[ch][1] * me1[ch] + mc[ch][2] * me2[ch]
            + ((mc[ch][3] * mu1[ch]) >>> FRAC_W) + ((mc[ch][4] * mu2[ch]) >>> FRAC_W);
        lim = ((128'sd1 <<< ADC_W) - 128'sd1) * (128'sd1 <<< FRAC_W);
        sat = (acc > lim) || (acc < -lim);
        cl  = (acc > lim) ? lim : ((acc < -lim) ? -lim : acc);
        val = longint'(cl >>> FRAC_W);
        me2[ch] = me1[ch];
        me1[ch] = e;
        mu2[ch] = mu1[ch];
        mu1[ch] = cl;
    endtask

    typedef struct {
        bit          is_run;
        int          ch;
        int          idx;
        logic [31:0] data;
        int          sp;
        int          ad;
        longint      exp_val;
        bit          exp_sat;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        longint val, mval;
        bit     sat, msat, err;
        int     och, lat, dones;

        // Writes: {0, ch, idx, data, -, -, -, -, exp_err}; runs: {1, ch, -, -, set, adc, val, sat, -}
        tbl.push_back('{1'b0, 0, 0, 32'd16777216,  0,   0,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 0, 0, 32'd0,       100,  40,  60, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 0, 0, 32'd167772160, 0,   0,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 0, 3, 32'd16777216,  0,   0,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 0, 0, 32'd0,       200,   0, 255, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 0, 0, 32'd0,        50,  50, 255, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2, 0, 32'd8388608,   0,   0,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2, 3, 32'd16777216,  0,   0,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 32'd0,        20,  10,   5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 32'd0,        20,  10,  10, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 32'd0,        20,  10,  15, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1, 0, 32'd0,        77,  33,   0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 32'd0,        20,  10,  20, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 32'd0,         0,  10,  15, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1, 5, 32'd123,       0,   0,   0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 3, 7, 32'd5,         0,   0,   0, 1'b0, 1'b1});

        do_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_val", out_val_o, 0);
        chk("rst_ch", out_ch_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_err", coef_err_o, 0);

        foreach (tbl[i]) begin
            if (!tbl[i].is_run) begin
                wr_coef(tbl[i].ch, tbl[i].idx, tbl[i].data, err);
                chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            end else begin
                run(tbl[i].ch, tbl[i].sp, tbl[i].ad, val, sat, och, lat);
                chk($sformatf("tbl%0d_lat", i), lat, 6);
                chk($sformatf("tbl%0d_val", i), val, tbl[i].exp_val);
                chk($sformatf("tbl%0d_sat", i), sat, tbl[i].exp_sat);
                chk($sformatf("tbl%0d_ch", i), och, tbl[i].ch);
            end
        end

        // Second start two cycles into a computation is dropped.
        wr_coef(3, 0, 32'd16777216, err);
        chk("ch3_b0_err", err, 0);
        start_i = 1'b1; ch_i = 2'd3; set_i = 8'd100; adc_i = 8'd40;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        tick();
        start_i = 1'b1; ch_i = 2'd3; set_i = 8'd200; adc_i = 8'd0;
        tick();
        start_i = 1'b0;
        dones = 0;
        val = -1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o) begin
                dones++;
                val = longint'($signed(out_val_o));
            end
        end
        chk("busy_start_dones", dones, 1);
        chk("busy_start_val", val, 60);

        // Coefficient write during a computation is rejected with a single pulse.
        start_i = 1'b1; ch_i = 2'd3; set_i = 8'd100; adc_i = 8'd40;
        tick();
        start_i = 1'b0;
        tick();
        wr_coef(3, 0, 32'd33554432, err);
        chk("busy_wr_err", err, 1);
        tick();
        chk("busy_wr_err_pulse", coef_err_o, 0);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (done_o) begin lat = i; break; end
            tick();
        end
        chk("busy_wr_done_seen", (lat >= 0), 1);
        tick();
        run(3, 100, 40, val, sat, och, lat);
        chk("busy_wr_coef_kept", val, 60);
        chk("busy_wr_ch", och, 3);

        // Reset mid-computation discards the result and clears everything.
        start_i = 1'b1; ch_i = 2'd0; set_i = 8'd100; adc_i = 8'd40;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_val", out_val_o, 0);
        chk("midrst_ch", out_ch_o, 0);
        chk("midrst_sat", sat_o, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_o) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run(0, 100, 40, val, sat, och, lat);
        chk("midrst_run_lat", lat, 6);
        chk("midrst_run_val", val, 0);
        chk("midrst_run_sat", sat, 0);

        // Randomized writes and runs against the reference model.
        do_reset();
        m_reset();
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                int          c, k;
                logic [31:0] d;
                c = $urandom_range(0, CHN - 1);
                k = $urandom_range(0, 7);
                if ($urandom_range(0, 3) == 0) d = $urandom;
                else d = 32'($urandom_range(0, 1 << 26)) - 32'(1 << 25);
                wr_coef(c, k, d, err);
                chk($sformatf("rnd%0d_err", it), err, (k > 4));
                if (k <= 4) m_write(c, k, d);
            end
            begin
                int c, sp, ad;
                c  = $urandom_range(0, CHN - 1);
                sp = $urandom_range(0, 255);
                ad = $urandom_range(0, 255);
                run(c, sp, ad, val, sat, och, lat);
                m_run(c, sp, ad, mval, msat);
                chk($sformatf("rnd%0d_lat", it), lat, 6);
                chk($sformatf("rnd%0d_val", it), val, mval);
                chk($sformatf("rnd%0d_sat", it), sat, msat);
                chk($sformatf("rnd%0d_ch", it), och, c);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
